// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU scheduler: opcodes, status codes,
// FSM states and the fixed unit index map.
package alu_pkg;

  localparam int DATA_W    = 32;
  localparam int NUM_UNITS = 3;

  localparam int UNIT_ADD = 0;
  localparam int UNIT_MUL = 1;
  localparam int UNIT_DIV = 2;

  typedef enum logic [1:0] {
    ADD     = 2'd0,
    MUL     = 2'd1,
    DIV     = 2'd2,
    ILLEGAL = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    OK         = 2'd0,
    ILLEGAL_OP = 2'd1,
    TIMEOUT    = 2'd2
  } err_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  // Opcode to one-hot unit select; the illegal opcode selects nothing.
  function automatic logic [NUM_UNITS-1:0] unit_onehot(op_e op);
    logic [NUM_UNITS-1:0] oh;
    oh = '0;
    case (op)
      ADD:     oh[UNIT_ADD] = 1'b1;
      MUL:     oh[UNIT_MUL] = 1'b1;
      DIV:     oh[UNIT_DIV] = 1'b1;
      default: oh = '0;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/alu_sched_if.sv
// Command, unit and response channels of the ALU scheduler.
// The scheduler uses the slave modport; the parser/unit side uses master.
interface alu_sched_if;
  import alu_pkg::*;

  logic                 cmd_valid_i;
  logic                 cmd_ready_o;
  logic [1:0]           cmd_op_i;
  logic [DATA_W-1:0]    cmd_a_i;
  logic [DATA_W-1:0]    cmd_b_i;

  logic [NUM_UNITS-1:0] unit_valid_o;
  logic [NUM_UNITS-1:0] unit_ready_i;
  logic [DATA_W-1:0]    operand_a_o;
  logic [DATA_W-1:0]    operand_b_o;
  logic [NUM_UNITS-1:0] unit_valid_i;
  logic [NUM_UNITS-1:0] unit_ready_o;
  logic [DATA_W-1:0]    add_result_i;
  logic [DATA_W-1:0]    mul_result_i;
  logic [DATA_W-1:0]    div_result_i;

  logic                 rsp_valid_o;
  logic                 rsp_ready_i;
  logic [DATA_W-1:0]    rsp_data_o;
  logic [1:0]           rsp_err_o;
  logic                 busy_o;

  modport slave (
    input  cmd_valid_i, cmd_op_i, cmd_a_i, cmd_b_i,
    input  unit_ready_i, unit_valid_i, add_result_i, mul_result_i, div_result_i,
    input  rsp_ready_i,
    output cmd_ready_o, unit_valid_o, operand_a_o, operand_b_o, unit_ready_o,
    output rsp_valid_o, rsp_data_o, rsp_err_o, busy_o
  );

  modport master (
    output cmd_valid_i, cmd_op_i, cmd_a_i, cmd_b_i,
    output unit_ready_i, unit_valid_i, add_result_i, mul_result_i, div_result_i,
    output rsp_ready_i,
    input  cmd_ready_o, unit_valid_o, operand_a_o, operand_b_o, unit_ready_o,
    input  rsp_valid_o, rsp_data_o, rsp_err_o, busy_o
  );

endinterface

// File: rtl/alu_sched.sv
// Single-outstanding-operation scheduler: dispatches one command to the add,
// multiply or divide unit, returns its result, and times out hung units.
module alu_sched
  import alu_pkg::*;
#(
  parameter  int TIMEOUT_CYCLES = 64,
  localparam int TW             = $clog2(TIMEOUT_CYCLES + 1)
) (
  input logic        clk_i,
  input logic        reset_ni,
  alu_sched_if.slave bus
);

  state_e               state_reg, state_next;
  op_e                  op_reg, op_next;
  logic [DATA_W-1:0]    a_reg, a_next;
  logic [DATA_W-1:0]    b_reg, b_next;
  logic [TW-1:0]        wdog_reg, wdog_next;
  logic [NUM_UNITS-1:0] stale_reg, stale_next;
  logic [DATA_W-1:0]    rsp_data_reg, rsp_data_next;
  err_e                 rsp_err_reg, rsp_err_next;

  logic [NUM_UNITS-1:0] sel_oh;
  logic [NUM_UNITS-1:0] unit_valid;
  logic [NUM_UNITS-1:0] stale_set;
  logic [DATA_W-1:0]    sel_result;

  assign sel_oh = unit_onehot(op_reg);

  always_comb begin
    sel_result = bus.add_result_i;
    case (op_reg)
      MUL:     sel_result = bus.mul_result_i;
      DIV:     sel_result = bus.div_result_i;
      default: sel_result = bus.add_result_i;
    endcase
  end

  // A unit with a result still in flight from an aborted op is not re-issued
  // until that result has drained; drain readiness is independent of state.
  generate
    for (genvar gi = 0; gi < NUM_UNITS; gi++) begin : g_unit
      assign unit_valid[gi]       = (state_reg == ISSUE) && sel_oh[gi] && !stale_reg[gi];
      assign bus.unit_ready_o[gi] = stale_reg[gi] | ((state_reg == WAIT) && sel_oh[gi]);
      assign stale_next[gi]       = stale_set[gi] | (stale_reg[gi] & ~bus.unit_valid_i[gi]);
    end
  endgenerate

  always_comb begin
    state_next    = state_reg;
    op_next       = op_reg;
    a_next        = a_reg;
    b_next        = b_reg;
    wdog_next     = wdog_reg;
    rsp_data_next = rsp_data_reg;
    rsp_err_next  = rsp_err_reg;
    stale_set     = '0;

    case (state_reg)
      IDLE: begin
        if (bus.cmd_valid_i) begin
          op_next = op_e'(bus.cmd_op_i);
          a_next  = bus.cmd_a_i;
          b_next  = bus.cmd_b_i;
          if (op_e'(bus.cmd_op_i) == ILLEGAL) begin
            rsp_err_next  = ILLEGAL_OP;
            rsp_data_next = '0;
            state_next    = RESP;
          end else begin
            state_next = ISSUE;
          end
        end
      end

      ISSUE: begin
        if (|(unit_valid & bus.unit_ready_i)) begin
          wdog_next  = '0;
          state_next = WAIT;
        end
      end

      WAIT: begin
        // A result landing on the timeout cycle takes priority.
        if (|(sel_oh & bus.unit_valid_i)) begin
          rsp_data_next = sel_result;
          rsp_err_next  = OK;
          state_next    = RESP;
        end else if (wdog_reg == TW'(TIMEOUT_CYCLES - 1)) begin
          stale_set     = sel_oh;
          rsp_data_next = '0;
          rsp_err_next  = TIMEOUT;
          state_next    = RESP;
        end else begin
          wdog_next = wdog_reg + TW'(1);
        end
      end

      RESP: begin
        if (bus.rsp_ready_i) begin
          state_next = IDLE;
        end
      end

      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      state_reg    <= IDLE;
      op_reg       <= ADD;
      a_reg        <= '0;
      b_reg        <= '0;
      wdog_reg     <= '0;
      stale_reg    <= '0;
      rsp_data_reg <= '0;
      rsp_err_reg  <= OK;
    end else begin
      state_reg    <= state_next;
      op_reg       <= op_next;
      a_reg        <= a_next;
      b_reg        <= b_next;
      wdog_reg     <= wdog_next;
      stale_reg    <= stale_next;
      rsp_data_reg <= rsp_data_next;
      rsp_err_reg  <= rsp_err_next;
    end
  end

  assign bus.cmd_ready_o  = (state_reg == IDLE);
  assign bus.unit_valid_o = unit_valid;
  assign bus.operand_a_o  = a_reg;
  assign bus.operand_b_o  = b_reg;
  assign bus.rsp_valid_o  = (state_reg == RESP);
  assign bus.rsp_data_o   = rsp_data_reg;
  assign bus.rsp_err_o    = rsp_err_reg;
  assign bus.busy_o       = (state_reg != IDLE);

endmodule

// File: doc/alu_sched.md
Name: alu_sched

Overview:
- Single-outstanding-operation scheduler between the UART command parser and the three arithmetic units: add, multiply and divide.
- Accepts one command (opcode plus two 32-bit operands) over a valid/ready handshake and dispatches it to the selected unit over that unit's valid/ready interface.
- Collects the unit's result and returns it with a status code over a valid/ready response channel.
- Guards against a hung unit with a watchdog timeout, and drains late results from aborted units.

Parameters:
- TIMEOUT_CYCLES, 64: WAIT-state cycles allowed before the operation is aborted. Must be at least 2.
- TW, $clog2(TIMEOUT_CYCLES+1): width of the watchdog counter (derived).

Ports:
- clk_i  in  1  clock
- reset_ni  in  1  reset; synchronous, active-low
- cmd_valid_i  in  1  command valid
- cmd_ready_o  out  1  command ready
- cmd_op_i  in  2  opcode: 0 ADD, 1 MUL, 2 DIV, 3 illegal
- cmd_a_i  in  32  operand A
- cmd_b_i  in  32  operand B
- unit_valid_o  out  3  one-hot request valid; bit 0 add, bit 1 mul, bit 2 div
- unit_ready_i  in  3  unit input ready
- operand_a_o  out  32  shared operand A bus to all units
- operand_b_o  out  32  shared operand B bus to all units
- unit_valid_i  in  3  unit result valid
- unit_ready_o  out  3  scheduler ready for the unit's result
- add_result_i  in  32  add unit result
- mul_result_i  in  32  multiply unit result
- div_result_i  in  32  divide unit result
- rsp_valid_o  out  1  response valid
- rsp_ready_i  in  1  response ready
- rsp_data_o  out  32  response result
- rsp_err_o  out  2  response status: 0 OK, 1 ILLEGAL_OP, 2 TIMEOUT
- busy_o  out  1  high in any state other than IDLE

Behaviour:
- Reset: while reset_ni=0 on a rising edge, state goes to IDLE and the watchdog, stale flags, op register, operand registers, rsp_data_o and rsp_err_o all clear to 0.
- Output values in IDLE after reset: cmd_ready_o=1, all other outputs 0.
- Reset asserted mid-operation aborts immediately; no response is produced.
- State IDLE:
  - cmd_ready_o=1.
  - On cmd handshake, latch op, a and b.
  - op=3: set rsp_err_o=1 and rsp_data_o=0, then go to RESP. No unit is touched.
  - Otherwise go to ISSUE.
- State ISSUE:
  - operand_a_o and operand_b_o carry the latched operands.
  - unit_valid_o[sel]=1 only when stale[sel]=0; it stays high until unit_ready_i[sel] is seen.
  - On that handshake, clear the watchdog and go to WAIT.
  - The watchdog does not run in ISSUE.
- State WAIT:
  - unit_ready_o[sel]=1.
  - If unit_valid_i[sel]=1: latch the selected result into rsp_data_o, set rsp_err_o=0, go to RESP.
  - Else, if the watchdog equals TIMEOUT_CYCLES-1: set stale[sel]=1, rsp_err_o=2, rsp_data_o=0, go to RESP.
  - Else increment the watchdog.
  - A result arriving in the same cycle as the timeout wins; the response is OK.
- State RESP:
  - rsp_valid_o=1; rsp_data_o and rsp_err_o are held stable until rsp_ready_i=1, then go to IDLE.
  - No new command is accepted until the state returns to IDLE.
- Stale drain, all states:
  - For every unit u with stale[u]=1, unit_ready_o[u]=1.
  - A unit_valid_i[u] pulse from such a unit is discarded and clears stale[u].
  - Stale handling never produces a response.
- Outputs are registered or decoded from state only; there is no combinational path from cmd_* or unit_*_i to any *_valid_o.
- Throughput: a fresh command is accepted at the earliest one cycle after the RESP handshake.
- ADD end-to-end timing, with a unit that registers once (valid on the cycle after accepting input): command handshake at cycle 0 gives rsp_valid_o at cycle 3.
- Results are 32 bits. No width extension is performed; the divide unit's divide-by-zero convention passes through unchanged with status OK.

Decomposition:
- Package alu_pkg holds:
  - op_e: ADD, MUL, DIV, ILLEGAL
  - err_e: OK, ILLEGAL_OP, TIMEOUT
  - state_e: IDLE, ISSUE, WAIT, RESP
  - UNIT_ADD, UNIT_MUL and UNIT_DIV index constants
- Single module; the watchdog counter stays inline. No sub-module is required.

Test Plan:
- ADD, a=0xFFFF_FFFF, b=2, real add unit, rsp_ready_i held high -> rsp_data_o=0x0000_0001, err 0, rsp_valid_o at cycle 3 after the command handshake.
- MUL 7 x 6, model with 5-cycle latency and unit_ready_i low for 2 cycles in ISSUE -> unit_valid_o[1] held for 3 cycles with stable operands; rsp 42, err 0.
- op=3, a=b=0x1234 -> no unit_valid_o activity; rsp_err_o=1, rsp_data_o=0, response 1 cycle after the handshake.
- DIV to a unit that never responds, TIMEOUT_CYCLES=8 -> rsp_err_o=2 after 8 WAIT cycles.
- Continuation of the DIV timeout case: div unit fires unit_valid_i[2] 10 cycles later -> it is absorbed silently. A DIV issued before that pulse holds unit_valid_o[2]=0 until the drain completes.
- Response backpressure: rsp_ready_i low for 4 cycles with cmd_valid_i high -> rsp_data_o stable and cmd_ready_o=0 throughout. Assert reset_ni=0 in WAIT -> IDLE on the next edge with all outputs at reset values.
